// File: rtl/counter_bus_arbiter.sv
// Round-robin arbiter sharing the counter bus between the WB and LA requesters.
// Optional watchdog enabled by defining COUNTER_ARB_TIMEOUT_EN.
module counter_bus_arbiter #(
  parameter int BITS           = 30,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            s0_valid,
  input  logic [3:0]      s0_wstrb,
  input  logic [BITS-1:0] s0_wdata,
  output logic            s0_ready,
  output logic [BITS-1:0] s0_rdata,
  output logic            s0_err,
  input  logic            s1_valid,
  input  logic [3:0]      s1_wstrb,
  input  logic [BITS-1:0] s1_wdata,
  output logic            s1_ready,
  output logic [BITS-1:0] s1_rdata,
  output logic            s1_err,
  output logic            m_valid,
  output logic [3:0]      m_wstrb,
  output logic [BITS-1:0] m_wdata,
  input  logic            m_ready,
  input  logic [BITS-1:0] m_rdata,
  output logic            busy,
  output logic            grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_d;
  logic            last_grant, last_grant_d;
  logic            grant_d, win;
  logic            m_valid_d;
  logic [3:0]      m_wstrb_d;
  logic [BITS-1:0] m_wdata_d;
  logic            s0_ready_d, s1_ready_d;
  logic [BITS-1:0] s0_rdata_d, s1_rdata_d;
  logic            busy_d;
  logic            done, done_err;
  logic [BITS-1:0] done_data;

`ifdef COUNTER_ARB_TIMEOUT_EN
  logic [7:0] wd, wd_d;
  logic       expire;
  logic       s0_err_d, s1_err_d;

  assign expire = (wd == 8'(TIMEOUT_CYCLES - 1));
`else
  assign s0_err = 1'b0;
  assign s1_err = 1'b0;
`endif

  // On contention the port that did not win last time goes first
  assign win = (s0_valid && s1_valid) ? ~last_grant : s1_valid;

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    grant_d      = grant;
    m_valid_d    = m_valid;
    m_wstrb_d    = m_wstrb;
    m_wdata_d    = m_wdata;
    s0_ready_d   = 1'b0;
    s1_ready_d   = 1'b0;
    s0_rdata_d   = s0_rdata;
    s1_rdata_d   = s1_rdata;
    busy_d       = busy;
    done         = 1'b0;
    done_err     = 1'b0;
    done_data    = m_rdata;
`ifdef COUNTER_ARB_TIMEOUT_EN
    wd_d         = wd;
    s0_err_d     = s0_err;
    s1_err_d     = s1_err;
`endif
    unique case (state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          grant_d      = win;
          last_grant_d = win;
          m_valid_d    = 1'b1;
          m_wstrb_d    = win ? s1_wstrb : s0_wstrb;
          m_wdata_d    = win ? s1_wdata : s0_wdata;
          busy_d       = 1'b1;
          state_d      = BUSY;
`ifdef COUNTER_ARB_TIMEOUT_EN
          wd_d         = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (m_ready) begin
          done = 1'b1;
`ifdef COUNTER_ARB_TIMEOUT_EN
        end else if (expire) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = '0;
        end else begin
          wd_d = wd + 8'd1;
`endif
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      m_valid_d = 1'b0;
      state_d   = RESP;
      unique case (1'b1)
        grant: begin
          s1_ready_d = 1'b1;
          s1_rdata_d = done_data;
        end
        default: begin
          s0_ready_d = 1'b1;
          s0_rdata_d = done_data;
        end
      endcase
`ifdef COUNTER_ARB_TIMEOUT_EN
      if (grant) s1_err_d = done_err;
      else       s0_err_d = done_err;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      m_valid    <= 1'b0;
      m_wstrb    <= '0;
      m_wdata    <= '0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
      s0_rdata   <= '0;
      s1_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      grant      <= grant_d;
      m_valid    <= m_valid_d;
      m_wstrb    <= m_wstrb_d;
      m_wdata    <= m_wdata_d;
      s0_ready   <= s0_ready_d;
      s1_ready   <= s1_ready_d;
      s0_rdata   <= s0_rdata_d;
      s1_rdata   <= s1_rdata_d;
      busy       <= busy_d;
    end
  end

`ifdef COUNTER_ARB_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd     <= 8'd0;
      s0_err <= 1'b0;
      s1_err <= 1'b0;
    end else begin
      wd     <= wd_d;
      s0_err <= s0_err_d;
      s1_err <= s1_err_d;
    end
  end
`else
  wire unused_ok = done_err;
`endif

endmodule

// File: tb/tb_counter_bus_arbiter.sv
// Directed bench for counter_bus_arbiter with a simple counter model.
// Exercises the watchdog when COUNTER_ARB_TIMEOUT_EN is defined.
module tb_counter_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [3:0]  s0_wstrb = '0, s1_wstrb = '0;
  logic [29:0] s0_wdata = '0, s1_wdata = '0;
  logic        s0_ready, s1_ready, s0_err, s1_err;
  logic [29:0] s0_rdata, s1_rdata;
  logic        m_valid, m_ready, busy, grant;
  logic [3:0]  m_wstrb;
  logic [29:0] m_wdata, m_rdata, ctr, ctr_val;
  logic        ctr_load = 1'b0;
  int          delay = 0;
  int          cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  counter_bus_arbiter #(.BITS(30), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .s0_valid(s0_valid), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
    .s0_ready(s0_ready), .s0_rdata(s0_rdata), .s0_err(s0_err),
    .s1_valid(s1_valid), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata), .s1_err(s1_err),
    .m_valid(m_valid), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .grant(grant)
  );

  function automatic logic [29:0] wmerge(input logic [29:0] o,
                                         input logic [3:0] s,
                                         input logic [29:0] d);
    logic [31:0] a, b;
    a = {2'b00, o};
    b = {2'b00, d};
    for (int i = 0; i < 4; i++)
      if (s[i]) a[8*i +: 8] = b[8*i +: 8];
    return a[29:0];
  endfunction

  // Counter model: ready one cycle after valid plus 'delay' extra cycles
  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      cnt     <= 0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
      cnt     <= 0;
    end else if (m_valid) begin
      if (cnt >= delay) begin
        m_ready <= 1'b1;
        m_rdata <= ctr;
        ctr     <= wmerge(ctr, m_wstrb, m_wdata);
        cnt     <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
    if (ctr_load) ctr <= ctr_val;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_checks++; if (m_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_m_wstrb got %h want 0", m_wstrb); end
    n_checks++; if (m_wdata !== 30'h0) begin n_fail++; $display("FAIL reset_m_wdata got %h want 0", m_wdata); end
    n_checks++; if ({s0_ready, s1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {s0_ready, s1_ready}); end
    n_checks++; if ({s0_err, s1_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", {s0_err, s1_err}); end
    n_checks++; if ({s0_rdata, s1_rdata} !== 60'h0) begin n_fail++; $display("FAIL reset_rdata got %h %h want 0", s0_rdata, s1_rdata); end
    n_checks++; if ({busy, grant} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_grant got %b want 00", {busy, grant}); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    ctr_val  = 30'h55;
    ctr_load = 1'b1;
    @(posedge clk); #1;
    ctr_load = 1'b0;
    s0_valid = 1'b1; s0_wstrb = 4'hF; s0_wdata = 30'h123;
    @(posedge clk); #1;
    n_checks++; if ({m_valid, busy, grant, s0_ready} !== 4'b1100) begin n_fail++; $display("FAIL single_grant got %b want 1100", {m_valid, busy, grant, s0_ready}); end
    n_checks++; if ({m_wstrb, m_wdata} !== {4'hF, 30'h123}) begin n_fail++; $display("FAIL single_mbus got %h %h want f 123", m_wstrb, m_wdata); end
    s0_wdata = 30'h3FF;
    @(posedge clk); #1;
    n_checks++; if ({m_valid, s0_ready, m_wdata} !== {2'b10, 30'h123}) begin n_fail++; $display("FAIL single_hold got %b %b %h want 1 0 123", m_valid, s0_ready, m_wdata); end
    @(posedge clk); #1;
    n_checks++; if ({s0_ready, s0_err, m_valid} !== 3'b100) begin n_fail++; $display("FAIL single_ready got %b want 100", {s0_ready, s0_err, m_valid}); end
    n_checks++; if (s0_rdata !== 30'h55) begin n_fail++; $display("FAIL single_rdata got %h want 55", s0_rdata); end
    @(posedge clk); #1;
    s0_valid = 1'b0;
    n_checks++; if ({s0_ready, busy, s0_rdata} !== {2'b00, 30'h55}) begin n_fail++; $display("FAIL single_after got %b %b %h want 0 0 55", s0_ready, busy, s0_rdata); end
  endtask

  task automatic test_contention;
    logic [3:0] e;
    rst = 1'b1;
    s0_valid = 1'b1; s0_wstrb = 4'h0;
    s1_valid = 1'b1; s1_wstrb = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      e = {(c % 4) < 2, (c % 8) == 2, (c % 8) == 6, ((c / 4) % 2) == 1};
      n_checks++;
      if ({m_valid, s0_ready, s1_ready, grant} !== e) begin
        n_fail++;
        $display("FAIL contention_c%0d got %b want %b", c, {m_valid, s0_ready, s1_ready, grant}, e);
      end
      if ((c % 4) == 2) begin
        n_checks++;
        if ((s0_ready ? s0_rdata : s1_rdata) !== 30'h123) begin
          n_fail++;
          $display("FAIL contention_rdata_c%0d got %h want 123", c, s0_ready ? s0_rdata : s1_rdata);
        end
      end
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_held;
    int rises = 0, readies = 0;
    logic prev = 1'b0, drop = 1'b0;
    s1_valid = 1'b1; s1_wstrb = 4'h1; s1_wdata = 30'h3A;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (drop) s1_valid = 1'b0;
      drop = s1_ready;
      if (m_valid && !prev) rises++;
      prev = m_valid;
      if (s1_ready) readies++;
      if (c == 2) begin
        n_checks++;
        if ({s1_ready, s1_rdata} !== {1'b1, 30'h123}) begin n_fail++; $display("FAIL held_ready got %b %h want 1 123", s1_ready, s1_rdata); end
      end
    end
    n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL held_mvalid_count got %0d want 1", rises); end
    n_checks++; if (readies !== 1) begin n_fail++; $display("FAIL held_ready_count got %0d want 1", readies); end
  endtask

  task automatic test_reset_busy;
    s0_valid = 1'b1; s0_wstrb = 4'h0;
    s1_valid = 1'b1; s1_wstrb = 4'h0;
    @(posedge clk); #1;
    n_checks++; if ({m_valid, grant} !== 2'b10) begin n_fail++; $display("FAIL rstbusy_first got %b want 10", {m_valid, grant}); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if ({m_valid, busy, s0_ready, s1_ready} !== 4'b0000) begin n_fail++; $display("FAIL rstbusy_abort got %b want 0000", {m_valid, busy, s0_ready, s1_ready}); end
    n_checks++; if (s0_rdata !== 30'h0) begin n_fail++; $display("FAIL rstbusy_rdata got %h want 0", s0_rdata); end
    @(posedge clk); #1;
    n_checks++; if ({m_valid, grant} !== 2'b10) begin n_fail++; $display("FAIL rstbusy_regrant got %b want 10", {m_valid, grant}); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({s0_ready, s1_ready, s0_rdata} !== {2'b10, 30'h13A}) begin n_fail++; $display("FAIL rstbusy_done got %b %h want 10 13a", {s0_ready, s1_ready}, s0_rdata); end
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef COUNTER_ARB_TIMEOUT_EN
  task automatic test_timeout;
    s1_valid = 1'b1; s1_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    s1_valid = 1'b0;
    n_checks++; if ({s1_ready, s1_err, s1_rdata} !== {2'b10, 30'h13A}) begin n_fail++; $display("FAIL to_pre got %b %h want 10 13a", {s1_ready, s1_err}, s1_rdata); end
    @(posedge clk); #1;
    delay = 1000;
    s1_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c < 16; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({m_valid, s1_ready} !== 2'b10) begin n_fail++; $display("FAIL to_wait_c%0d got %b want 10", c, {m_valid, s1_ready}); end
    end
    @(posedge clk); #1;
    n_checks++; if ({m_valid, s1_ready, s1_err} !== 3'b011) begin n_fail++; $display("FAIL to_expire got %b want 011", {m_valid, s1_ready, s1_err}); end
    n_checks++; if (s1_rdata !== 30'h0) begin n_fail++; $display("FAIL to_rdata got %h want 0", s1_rdata); end
    @(posedge clk); #1;
    s1_valid = 1'b0;
    delay = 0;
    @(posedge clk); #1;
    s1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({s1_ready, s1_err, s1_rdata} !== {2'b10, 30'h13A}) begin n_fail++; $display("FAIL to_after got %b %h want 10 13a", {s1_ready, s1_err}, s1_rdata); end
    @(posedge clk); #1;
    s1_valid = 1'b0;
    @(posedge clk); #1;
  endtask
`else
  task automatic test_slow;
    int j;
    delay = 40;
    s0_valid = 1'b1; s0_wstrb = 4'h0;
    for (j = 0; j < 100 && !m_ready; j++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (!m_ready || j < 41) begin
      n_fail++;
      $display("FAIL slow_mready got %b after %0d want 1 after >40", m_ready, j);
    end else begin
      n_checks++; if (s0_ready !== 1'b0) begin n_fail++; $display("FAIL slow_early got %b want 0", s0_ready); end
      @(posedge clk); #1;
      n_checks++; if ({s0_ready, s0_err, s0_rdata} !== {2'b10, 30'h13A}) begin n_fail++; $display("FAIL slow_ready got %b %h want 10 13a", {s0_ready, s0_err}, s0_rdata); end
    end
    s0_valid = 1'b0;
    delay = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    ctr_val  = 30'h0;
    ctr_load = 1'b1;
    test_reset;
    ctr_load = 1'b0;
    test_single;
    test_contention;
    test_back_to_back_held;
    test_reset_busy;
`ifdef COUNTER_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_slow;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bus_arbiter.md
# counter_bus_arbiter

Two-port arbiter that shares the user-area counter's single bus port (valid/wstrb/wdata in, ready/rdata out) between the Wishbone requester (port 0) and the logic-analyzer requester (port 1). It grants one transaction at a time with round-robin priority, drives the counter's handshake, and returns the read data to the granted requester. An optional watchdog terminates transactions that the counter never acknowledges.

## Interface
Parameters:
- BITS, 30, data width; matches the counter width.
- TIMEOUT_CYCLES, 16, BUSY cycles allowed before forced completion; legal range 2..255.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- s0_valid, s1_valid  in  1  request; held high until the matching sN_ready.
- s0_wstrb, s1_wstrb  in  4  byte write strobes; 0 = read only.
- s0_wdata, s1_wdata  in  BITS  write data.
- s0_ready, s1_ready  out  1  one-cycle completion pulse.
- s0_rdata, s1_rdata  out  BITS  counter value before the write; valid while sN_ready is high, held afterwards.
- s0_err, s1_err  out  1  timeout flag; valid with sN_ready.
- m_valid  out  1  to counter valid.
- m_wstrb  out  4  to counter wstrb.
- m_wdata  out  BITS  to counter wdata.
- m_ready  in  1  from counter ready.
- m_rdata  in  BITS  from counter rdata.
- busy  out  1  high in BUSY and RESP.
- grant  out  1  index of the current or last granted port.

## Operation
- FSM with three states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE: when any sN_valid is sampled high, pick a winner. If only one port requests, it wins. If both request, the port not in last_grant wins. Latch the winner's wstrb/wdata into m_wstrb/m_wdata, set m_valid=1, set grant and last_grant to the winner, and go to BUSY.
- BUSY: hold m_valid, m_wstrb and m_wdata stable. When m_ready is sampled high:
  - capture m_rdata into s<grant>_rdata;
  - set s<grant>_ready=1 and s<grant>_err=0;
  - set m_valid=0 and go to RESP.
- RESP: lasts exactly one cycle with the ready pulse high, then return to IDLE. Requests are not sampled in RESP, so a requester still holding valid during its ready cycle is not re-granted.
- The losing requester keeps valid high and is granted on the next IDLE decision.
- Requests arriving while busy are held by the requester; the arbiter never drops them.
- m_ready sampled in IDLE or RESP is ignored.
- Changes to sN_wstrb/sN_wdata after the grant are ignored.
- Reset values:
  - FSM = IDLE, m_valid=0, m_wstrb=0, m_wdata=0;
  - all sN_ready=0, sN_rdata=0, sN_err=0;
  - busy=0, grant=0;
  - last_grant=1, so port 0 wins the first contention.
- Reset mid-transaction (any state) aborts the transaction. Outputs take their reset values at the reset edge, and no ready pulse is issued for the aborted request.

## Timing
- Request sampled at edge k: m_valid is high from cycle k+1.
- The counter raises m_ready one cycle after sampling valid. The arbiter samples m_ready at edge k+2, and sN_ready is high for cycle k+3.
- Total latency with a compliant counter is 3 cycles from valid to ready.
- m_valid falls at the same edge sN_ready rises, so the counter never sees valid together with its own ready deasserted. There is no double access.
- The earliest next grant is sampled at edge k+4, one idle cycle after RESP. Back-to-back throughput is one transaction per 4 cycles.

## Configuration
- Macro: COUNTER_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with m_ready still low, the arbiter forces m_valid=0, s<grant>_ready=1, s<grant>_err=1 and s<grant>_rdata=0, then goes to RESP.
  - If m_ready and expiry occur in the same cycle, m_ready wins (normal completion, err=0).
- Undefined: no watchdog. BUSY waits indefinitely, and sN_err is tied to 0.

## Test plan
- Single request: s0 writes wstrb=4'hF, wdata=30'h123; counter model holds 30'h55 -> m_valid from k+1, s0_ready at k+3 with s0_rdata=30'h55 and err=0; m_wdata=30'h123.
- Contention: s0 and s1 both valid from reset -> grants go 0,1,0,1 over four transactions, 4 cycles apart; each ready pulse lasts exactly 1 cycle.
- Held valid through ready: requester drops valid one cycle after ready -> exactly one m_valid assertion per request.
- Timeout (macro defined, counter model never ready, TIMEOUT_CYCLES=16) -> s1_ready with s1_err=1 and s1_rdata=0 after 16 BUSY cycles; a following request completes normally with err=0.
- Reset asserted in BUSY -> the next cycle shows m_valid=0, busy=0 and no sN_ready; after reset, port 0 wins contention.
- Macro undefined, counter model ready after 40 cycles -> s0_ready is issued 1 cycle after m_ready, and err stays 0.
